// File: rtl/psram_rd_capt_pkg.sv
// -----------------------------------------------------------------------------
// psram_rd_capt_pkg
// Shared definitions for the PSRAM read-data capture stage:
//   - rcap_state_e         : capture FSM state encoding (2 bits)
//   - PSRAM_RCAP_MAX_BYTE  : largest burst the capture word can hold
//   - rcap_clamp_num()     : maps a requested byte count onto 1..8
//   - rcap_left_align()    : moves captured bytes up to the MSB end of the word
// -----------------------------------------------------------------------------
package psram_rd_capt_pkg;

    typedef enum logic [1:0] {
        PSRAM_RCAP_IDLE = 2'd0,
        PSRAM_RCAP_WAIT = 2'd1,
        PSRAM_RCAP_CAPT = 2'd2,
        PSRAM_RCAP_DONE = 2'd3
    } rcap_state_e;

    localparam logic [3:0] PSRAM_RCAP_MAX_BYTE = 4'd8;

    // A request of zero bytes still captures one; anything above the word
    // size is truncated to a full word.
    function automatic logic [3:0] rcap_clamp_num(input logic [3:0] num);
        logic [3:0] res;
        if (num == 4'd0) begin
            res = 4'd1;
        end else if (num > PSRAM_RCAP_MAX_BYTE) begin
            res = PSRAM_RCAP_MAX_BYTE;
        end else begin
            res = num;
        end
        return res;
    endfunction

    // Bytes are shifted in at the LSB end, so after `count` bytes they sit in
    // the low part of the word. Shift them up so the first byte lands in
    // [63:56]. count == 0 gives a shift of 64, i.e. an all-zero word.
    function automatic logic [63:0] rcap_left_align(input logic [63:0] data,
                                                    input logic [3:0]  count);
        logic [6:0] sh;
        sh = {(PSRAM_RCAP_MAX_BYTE - count), 3'b000};
        return data << sh;
    endfunction

endpackage : psram_rd_capt_pkg

// File: rtl/psram_rd_capt_dqs_det.sv
// -----------------------------------------------------------------------------
// psram_dqs_det
// Two-flop synchronizer for DQS and DQ, plus a both-edge detector on DQS.
// DQ goes through exactly the same number of stages as DQS so that the byte
// presented with edge_o is the one that was on the bus when DQS toggled.
//   clk_i   : core clock
//   rst_i   : synchronous active-high reset, clears every pipeline flop
//   dqs_i   : DQS from the pad
//   io_i    : DQ from the pad
//   edge_o  : high for one cycle per DQS transition (rise or fall)
//   byte_o  : DQ byte aligned with edge_o
// -----------------------------------------------------------------------------
module psram_dqs_det (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       dqs_i,
    input  logic [7:0] io_i,
    output logic       edge_o,
    output logic [7:0] byte_o
);

    logic       dqs_d1_q, dqs_d2_q, dqs_d3_q;
    logic       dqs_d1_d, dqs_d2_d, dqs_d3_d;
    logic [7:0] io_d1_q, io_d2_q;
    logic [7:0] io_d1_d, io_d2_d;

    always_comb begin
        dqs_d1_d = dqs_i;
        dqs_d2_d = dqs_d1_q;
        dqs_d3_d = dqs_d2_q;
        io_d1_d  = io_i;
        io_d2_d  = io_d1_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dqs_d1_q <= 1'b0;
            dqs_d2_q <= 1'b0;
            dqs_d3_q <= 1'b0;
            io_d1_q  <= 8'h00;
            io_d2_q  <= 8'h00;
        end else begin
            dqs_d1_q <= dqs_d1_d;
            dqs_d2_q <= dqs_d2_d;
            dqs_d3_q <= dqs_d3_d;
            io_d1_q  <= io_d1_d;
            io_d2_q  <= io_d2_d;
        end
    end

    // d3 exists only to compare against d2; the byte is taken from d2 so it
    // belongs to the DQS level that just appeared.
    assign edge_o = dqs_d2_q ^ dqs_d3_q;
    assign byte_o = io_d2_q;

endmodule : psram_dqs_det

// File: rtl/psram_rd_capt.sv
// -----------------------------------------------------------------------------
// psram_rd_capt
// Captures up to 8 DDR read bytes from the PSRAM pads (one per DQS edge),
// assembles them MSB-first into a 64-bit word and reports completion with a
// one-cycle done pulse. A programmable cycle timeout guards against a DQS that
// never arrives or stops early.
//   clk_i          : core clock (>= 4x PSRAM clock)
//   rst_i          : synchronous active-high reset
//   start_i        : begin a capture (accepted only when idle)
//   byte_num_i     : number of bytes to capture, clamped to 1..8
//   cfg_tout_i     : max cycles without a DQS edge, 0 disables the timeout
//   abort_i        : drop the capture and return to idle, no done pulse
//   psram_dqs_in_i : DQS pad input
//   psram_io_in_i  : DQ pad input
//   busy_o         : capture in progress (WAIT/CAPT)
//   done_o         : one-cycle completion / timeout pulse
//   err_o          : timeout flag, held until the next accepted start
//   rd_data_o      : left-aligned read word
//   cfg_data_o     : first captured byte (rd_data_o[63:56])
// -----------------------------------------------------------------------------
module psram_rd_capt
    import psram_rd_capt_pkg::*;
#(
    parameter int TOUT_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [3:0]            byte_num_i,
    input  logic [TOUT_WIDTH-1:0] cfg_tout_i,
    input  logic                  abort_i,
    input  logic                  psram_dqs_in_i,
    input  logic [7:0]            psram_io_in_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [63:0]           rd_data_o,
    output logic [7:0]            cfg_data_o
);

    localparam logic [TOUT_WIDTH-1:0] TOUT_ONE = {{(TOUT_WIDTH-1){1'b0}}, 1'b1};

    rcap_state_e           state_q, state_d;
    logic [3:0]            n_q, n_d;       // clamped byte count of this capture
    logic [3:0]            rem_q, rem_d;   // bytes still to capture
    logic [TOUT_WIDTH-1:0] tout_cfg_q, tout_cfg_d;
    logic [TOUT_WIDTH-1:0] tout_cnt_q, tout_cnt_d;
    logic [63:0]           rd_data_q, rd_data_d;
    logic                  err_q, err_d;

    logic                  det_edge;
    logic [7:0]            det_byte;
    logic [63:0]           shifted;
    logic [3:0]            rem_dec;
    logic [TOUT_WIDTH-1:0] tout_dec;
    logic                  tout_en;

    psram_dqs_det u_dqs_det (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .dqs_i  (psram_dqs_in_i),
        .io_i   (psram_io_in_i),
        .edge_o (det_edge),
        .byte_o (det_byte)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PSRAM_RCAP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------- next state + datapath
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        rem_d      = rem_q;
        tout_cfg_d = tout_cfg_q;
        tout_cnt_d = tout_cnt_q;
        rd_data_d  = rd_data_q;
        err_d      = err_q;

        shifted  = {rd_data_q[55:0], det_byte};
        rem_dec  = rem_q - 4'd1;
        tout_dec = tout_cnt_q - TOUT_ONE;
        tout_en  = (tout_cfg_q != '0);

        // Abort has priority over everything, including an edge arriving in
        // the same cycle: that byte is simply lost.
        if (abort_i) begin
            state_d = PSRAM_RCAP_IDLE;
        end else begin
            unique case (state_q)
                PSRAM_RCAP_IDLE: begin
                    if (start_i) begin
                        n_d        = rcap_clamp_num(byte_num_i);
                        rem_d      = rcap_clamp_num(byte_num_i);
                        tout_cfg_d = cfg_tout_i;
                        tout_cnt_d = cfg_tout_i;
                        rd_data_d  = 64'h0;
                        err_d      = 1'b0;
                        state_d    = PSRAM_RCAP_WAIT;
                    end
                end
                PSRAM_RCAP_WAIT,
                PSRAM_RCAP_CAPT: begin
                    if (det_edge) begin
                        // An edge always reloads the timeout, even in the
                        // cycle where the counter would have expired.
                        rem_d      = rem_dec;
                        tout_cnt_d = tout_cfg_q;
                        if (rem_dec == 4'd0) begin
                            rd_data_d = rcap_left_align(shifted, n_q);
                            state_d   = PSRAM_RCAP_DONE;
                        end else begin
                            rd_data_d = shifted;
                            state_d   = PSRAM_RCAP_CAPT;
                        end
                    end else if (tout_en) begin
                        tout_cnt_d = tout_dec;
                        if (tout_dec == '0) begin
                            err_d     = 1'b1;
                            rd_data_d = rcap_left_align(rd_data_q, n_q - rem_q);
                            state_d   = PSRAM_RCAP_DONE;
                        end
                    end
                end
                PSRAM_RCAP_DONE: begin
                    state_d = PSRAM_RCAP_IDLE;
                end
                default: begin
                    state_d = PSRAM_RCAP_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_q        <= 4'd0;
            rem_q      <= 4'd0;
            tout_cfg_q <= '0;
            tout_cnt_q <= '0;
            rd_data_q  <= 64'h0;
            err_q      <= 1'b0;
        end else begin
            n_q        <= n_d;
            rem_q      <= rem_d;
            tout_cfg_q <= tout_cfg_d;
            tout_cnt_q <= tout_cnt_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
        end
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        busy_o     = (state_q == PSRAM_RCAP_WAIT) || (state_q == PSRAM_RCAP_CAPT);
        done_o     = (state_q == PSRAM_RCAP_DONE);
        err_o      = err_q;
        rd_data_o  = rd_data_q;
        cfg_data_o = rd_data_q[63:56];
    end

endmodule : psram_rd_capt

// File: tb/tb_psram_rd_capt.sv
// -----------------------------------------------------------------------------
// tb_psram_rd_capt
// Table-driven vectors for the capture stage plus hand-written sequences for
// abort, reset, ignored start, idle DQS activity and disabled timeout.
// -----------------------------------------------------------------------------
module tb_psram_rd_capt;

    localparam int POLL_LIMIT = 200;
    localparam int NVEC       = 8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  byte_num;
    logic [7:0]  cfg_tout;
    logic        abort;
    logic        dqs;
    logic [7:0]  io;
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] rd_data;
    logic [7:0]  cfg_data;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    typedef struct {
        logic [3:0]  n;
        logic [7:0]  tout;
        int          nsend;
        logic [63:0] bytes;     // bytes to send, first one in [63:56]
        logic [63:0] exp_data;
        logic        exp_err;
        int          exp_lat;   // cycles from last stimulus to done
    } vec_t;

    vec_t vecs [NVEC];

    psram_rd_capt #(.TOUT_WIDTH(8)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .byte_num_i     (byte_num),
        .cfg_tout_i     (cfg_tout),
        .abort_i        (abort),
        .psram_dqs_in_i (dqs),
        .psram_io_in_i  (io),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .rd_data_o      (rd_data),
        .cfg_data_o     (cfg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // One DDR beat: new byte and a DQS transition, held for 2 clk cycles.
    task automatic send_byte(input logic [7:0] b);
        io  = b;
        dqs = ~dqs;
        tick();
        tick();
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= POLL_LIMIT; i++) begin
            tick();
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic do_start(input logic [3:0] n, input logic [7:0] tout);
        start    = 1'b1;
        byte_num = n;
        cfg_tout = tout;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          d0;
        logic [63:0] tmp;

        vecs[0] = '{4'd8,  8'd0,  8, 64'h1122334455667788, 64'h1122334455667788, 1'b0, 1};
        vecs[1] = '{4'd1,  8'd0,  1, 64'hA500000000000000, 64'hA500000000000000, 1'b0, 1};
        vecs[2] = '{4'd3,  8'd20, 3, 64'h0102030000000000, 64'h0102030000000000, 1'b0, 1};
        vecs[3] = '{4'd0,  8'd0,  1, 64'h5A00000000000000, 64'h5A00000000000000, 1'b0, 1};
        vecs[4] = '{4'd15, 8'd0,  8, 64'hF0F1F2F3F4F5F6F7, 64'hF0F1F2F3F4F5F6F7, 1'b0, 1};
        vecs[5] = '{4'd4,  8'd10, 2, 64'hDEAD000000000000, 64'hDEAD000000000000, 1'b1, 11};
        vecs[6] = '{4'd2,  8'd5,  0, 64'h0,                64'h0,                1'b1, 5};
        vecs[7] = '{4'd2,  8'd3,  2, 64'hC3C4000000000000, 64'hC3C4000000000000, 1'b0, 1};

        rst = 1'b1; start = 1'b0; byte_num = 4'd0; cfg_tout = 8'd0;
        abort = 1'b0; dqs = 1'b0; io = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_data", rd_data, 64'h0);
        chk("reset_cfg", 64'(cfg_data), 64'h0);

        // ---------------------------------------------------- table vectors
        for (int v = 0; v < NVEC; v++) begin
            do_start(vecs[v].n, vecs[v].tout);
            chk($sformatf("v%0d_busy_rise", v), 64'(busy), 64'd1);
            tmp = vecs[v].bytes;
            for (int i = 0; i < vecs[v].nsend; i++) send_byte(tmp[63-8*i -: 8]);
            wait_done(lat);
            chk($sformatf("v%0d_done_lat", v), 64'(lat), 64'(vecs[v].exp_lat));
            chk($sformatf("v%0d_data", v), rd_data, vecs[v].exp_data);
            chk($sformatf("v%0d_cfg", v), 64'(cfg_data), 64'(vecs[v].exp_data[63:56]));
            chk($sformatf("v%0d_err", v), 64'(err), 64'(vecs[v].exp_err));
            chk($sformatf("v%0d_busy_fall", v), 64'(busy), 64'd0);
            tick();
            chk($sformatf("v%0d_done_pulse", v), 64'(done), 64'd0);
            chk($sformatf("v%0d_err_held", v), 64'(err), 64'(vecs[v].exp_err));
            repeat (3) tick();
        end

        // ------------------------------------ N=1 then extra edges ignored
        do_start(4'd1, 8'd0);
        send_byte(8'hA5);
        wait_done(lat);
        chk("n1_lat", 64'(lat), 64'd1);
        chk("n1_cfg", 64'(cfg_data), 64'hA5);
        d0 = done_cnt;
        send_byte(8'h3C);
        send_byte(8'h3D);
        repeat (4) tick();
        chk("n1_extra_done", 64'(done_cnt), 64'(d0 + 1));
        chk("n1_extra_data", rd_data, 64'hA500000000000000);

        // ------------------------------------------- abort after 3 bytes
        do_start(4'd8, 8'd0);
        send_byte(8'h77);
        send_byte(8'h66);
        send_byte(8'h55);
        tick();
        d0 = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        repeat (5) tick();
        chk("abort_no_done", 64'(done_cnt), 64'(d0));
        chk("abort_data_kept", rd_data, 64'h0000000000776655);
        do_start(4'd2, 8'd0);
        send_byte(8'h12);
        send_byte(8'h34);
        wait_done(lat);
        chk("post_abort_lat", 64'(lat), 64'd1);
        chk("post_abort_data", rd_data, 64'h1234000000000000);
        repeat (3) tick();

        // --------------------------- abort in the same cycle as an edge
        do_start(4'd2, 8'd0);
        d0 = done_cnt;
        send_byte(8'h99);        // now in the detection cycle of this edge
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_edge_busy", 64'(busy), 64'd0);
        chk("abort_edge_data", rd_data, 64'h0);
        repeat (4) tick();
        chk("abort_edge_no_done", 64'(done_cnt), 64'(d0));

        // ------------------------------------- start while busy ignored
        do_start(4'd4, 8'd0);
        send_byte(8'hAA);
        start    = 1'b1;
        byte_num = 4'd1;
        tick();
        start    = 1'b0;
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        wait_done(lat);
        chk("busy_start_lat", 64'(lat), 64'd1);
        chk("busy_start_data", rd_data, 64'hAABBCCDD00000000);
        repeat (3) tick();

        // ------------------------------------------ reset mid-capture
        do_start(4'd8, 8'd0);
        send_byte(8'hAB);
        send_byte(8'hCD);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_data", rd_data, 64'h0);
        chk("rst_cfg", 64'(cfg_data), 64'h0);
        repeat (4) tick();

        // -------------------- DQS activity while idle, then a capture
        send_byte(8'hEE);
        send_byte(8'hEF);
        send_byte(8'hF0);
        repeat (4) tick();
        chk("idle_dqs_busy", 64'(busy), 64'd0);
        do_start(4'd2, 8'd0);
        send_byte(8'h21);
        send_byte(8'h43);
        wait_done(lat);
        chk("idle_dqs_lat", 64'(lat), 64'd1);
        chk("idle_dqs_data", rd_data, 64'h2143000000000000);
        repeat (3) tick();

        // ------------------------------ timeout disabled, no DQS at all
        d0 = done_cnt;
        do_start(4'd2, 8'd0);
        repeat (500) tick();
        chk("tout_off_no_done", 64'(done_cnt), 64'(d0));
        chk("tout_off_busy", 64'(busy), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("tout_off_abort", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_psram_rd_capt

// File: doc/psram_rd_capt.md
# psram_rd_capt

Read-data capture stage directly downstream of the PSRAM controller FSM's RDATA phase. Samples `psram_io_in_i` on every DQS edge (DDR), assembles up to 8 bytes MSB-first into a 64-bit word, and presents it to the bus side as `rd_data_o` with a one-cycle `done_o` pulse. Guards against a missing DQS with a programmable timeout. Runs entirely in `clk_i`, which is 4x or more the PSRAM clock.

## Interface
Parameters:
- `TOUT_WIDTH`, 8: width of the timeout counter and `cfg_tout_i`.

Ports:
- `clk_i` in 1: core clock, same clock as the PSRAM controller.
- `rst_i` in 1: reset. One clock; reset is synchronous and active-high.
- `start_i` in 1: one-cycle pulse as the controller enters RDATA. Ignored unless the block is in IDLE.
- `byte_num_i` in 4: bytes to capture, 1..8. Sampled on `start_i`. A value of 0 is treated as 1; values above 8 are treated as 8.
- `cfg_tout_i` in TOUT_WIDTH: maximum number of `clk_i` cycles allowed without a DQS edge. Sampled on `start_i`. A value of 0 disables the timeout.
- `abort_i` in 1: aborts the capture and returns the block to IDLE.
- `psram_dqs_in_i` in 1: DQS from the pad.
- `psram_io_in_i` in 8: DQ from the pad.
- `busy_o` out 1: high in WAIT and CAPT.
- `done_o` out 1: one-cycle pulse when a capture completes or times out.
- `err_o` out 1: timeout flag. Valid with `done_o`, held until the next `start_i`.
- `rd_data_o` out 64: assembled read word. Held until the next accepted `start_i`.
- `cfg_data_o` out 8: equals `rd_data_o[63:56]`; single-byte config reads use this output.

## Operation
Input path:
- `psram_dqs_in_i` and `psram_io_in_i` pass through identical 2-flop stages (d1, d2).
- A third flop d3 holds the DQS value only.
- An edge is detected when `dqs_d2 != dqs_d3`, in either direction.
- The byte captured on an edge is `io_d2`, which keeps data aligned with DQS.

States, encoded in the shared package:
- IDLE: `busy_o` is 0. On `start_i`:
  - latch `byte_num_i` (clamped) into `rem`;
  - latch `cfg_tout_i` into `tout_cnt`;
  - clear `rd_data_o` to 0 and `err_o` to 0;
  - go to WAIT.
- WAIT: waits for the first DQS edge. Edges while in IDLE are discarded, which covers DQS toggles seen before `start_i`.
  - On an edge: shift the byte in, decrement `rem`, reload `tout_cnt`, go to CAPT.
  - If `rem` reaches 0 on that edge, go to DONE instead.
- CAPT: each edge shifts the byte in (`rd_data = {rd_data[55:0], byte}`), decrements `rem` and reloads `tout_cnt`. When `rem` reaches 0, go to DONE.
- DONE: one cycle. `done_o` is 1.
  - The captured bytes are left-aligned: the first byte sits in `[63:56]` and the lower unfilled bytes are 0.
  - To achieve this, the final value is shifted left by `8*(8-N)` before it is registered.
  - Next state is IDLE.
- Timeout: in WAIT or CAPT, `tout_cnt` decrements on every cycle with no edge (when the timeout is enabled). When it reaches 0:
  - set `err_o`;
  - go to DONE;
  - `rd_data_o` holds the partial bytes, left-aligned as above.
- `abort_i`: in any state, next state is IDLE. No `done_o` pulse. `rd_data_o` and `err_o` keep their current values.

Boundary cases:
- `abort_i` and a DQS edge in the same cycle: abort wins and the byte is dropped.
- Timeout expiring and an edge in the same cycle: the edge wins and the counter reloads.
- More than N edges: the extra edges after DONE are ignored.
- `start_i` while busy: ignored, with no state change.
- `rst_i` mid-capture: the block is in IDLE on the next cycle, all outputs take their reset values, and the pipeline flops are cleared.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `err_o`=0, `rd_data_o`=0, `cfg_data_o`=0, state=IDLE, d1/d2/d3=0.
- A DQS transition sampled at clock edge k is detected in cycle k+1→k+2. The byte is registered at edge k+2.
- `done_o` is high in the cycle after the Nth byte is registered. Latency from the last DQS transition to `done_o` is 3 cycles.
- `busy_o` rises in the cycle after `start_i` and falls in the DONE cycle.
- Minimum DQS half-period is 2 `clk_i` cycles (DIV4). Edges closer together than that are not supported.

## Structure
- Add to `psram_define.sv`: `PSRAM_RCAP_IDLE`, `PSRAM_RCAP_WAIT`, `PSRAM_RCAP_CAPT`, `PSRAM_RCAP_DONE` (2-bit encodings), and `PSRAM_RCAP_MAX_BYTE` = 8.
- One sub-module, `psram_dqs_det`: the 2-flop DQS/DQ synchronizer plus both-edge detector. Outputs `edge_o` and `byte_o`.
- Registers use the existing `dffr`/`dffer` flop cells.

## Test plan
- N=8, DQS toggling every 2 cycles, bytes 0x11..0x88 → `rd_data_o`=0x1122334455667788, one `done_o` pulse, `err_o`=0.
- N=1, byte 0xA5 → `rd_data_o`=0xA500000000000000, `cfg_data_o`=0xA5; a second DQS edge afterwards has no effect.
- N=4, `cfg_tout_i`=10, DQS stops after 2 bytes 0xDE, 0xAD → `done_o` and `err_o` asserted 10 cycles after the last edge, `rd_data_o`=0xDEAD000000000000.
- N=8, `abort_i` pulsed after 3 bytes → IDLE next cycle, no `done_o`; a following `start_i` with N=2 (0x12, 0x34) → `rd_data_o`=0x1234000000000000.
- `rst_i` pulsed mid-capture → all outputs 0 the next cycle; `start_i` during busy is ignored, with `byte_num_i` unchanged in effect.
- DQS toggling while IDLE, then `start_i`, N=2 → only post-start bytes captured; timeout disabled (`cfg_tout_i`=0) with 500 idle cycles → no `done_o`.
